alu_operand_sequencer: RTL

//  Front-end stage that feeds the 5-bit ALU on the board. Debounces two push buttons and steps a

---
 rtl/alu_operand_sequencer_if.sv | 24 ++
 rtl/alu_operand_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer_if.sv
// Signal bundle between the operand sequencer, the board I/O and the 5-bit ALU.
// master = sequencer side, slave = board/ALU side.
interface alu_operand_sequencer_if;
    logic [4:0] sw;
    logic       btn_enter;
    logic       btn_clear;
    logic [3:0] alu_flags;
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] alu_control;
    logic [3:0] flags_hold;
    logic       result_valid;
    logic [2:0] state;

    modport master (
        input  sw, btn_enter, btn_clear, alu_flags,
        output a, b, alu_control, flags_hold, result_valid, state
    );

    modport slave (
        output sw, btn_enter, btn_clear, alu_flags,
        input  a, b, alu_control, flags_hold, result_valid, state
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// ALU front end: debounces enter/clear buttons and steps through operand A, operand B and
// opcode capture, then freezes the ALU flags while the result is shown.
module alu_operand_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                           clk,
    input  logic                           reset,
    alu_operand_sequencer_if.master        bus
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        StLoadA  = 3'd0,
        StLoadB  = 3'd1,
        StLoadOp = 3'd2,
        StExec   = 3'd3,
        StShow   = 3'd4
    } state_t;

    // Index 0 = enter, index 1 = clear.
    logic [1:0]    w_btn;
    logic [1:0]    r_sync0;
    logic [1:0]    r_sync1;
    logic [1:0]    r_db;
    logic [1:0]    r_db_d;
    logic [1:0]    r_pulse;
    logic [CW-1:0] r_cnt [2];

    logic          w_enter_p;
    logic          w_clear_p;

    state_t        r_state;
    logic [4:0]    r_a;
    logic [4:0]    r_b;
    logic [1:0]    r_op;
    logic [3:0]    r_flags;
    logic          r_valid;

    assign w_btn     = {bus.btn_clear, bus.btn_enter};
    assign w_enter_p = r_pulse[0];
    assign w_clear_p = r_pulse[1];

    // Synchronize, debounce and edge-detect both buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            r_pulse <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync0 <= w_btn;
            r_sync1 <= r_sync0;
            r_db_d  <= r_db;
            // Only a released->pressed transition of the accepted level pulses.
            r_pulse <= r_db & ~r_db_d;
            for (int i = 0; i < 2; i++) begin
                if (r_sync1[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_db[i]  <= r_sync1[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Capture FSM; clear beats enter, unknown codes fall back to a zeroed LOAD_A.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StLoadA;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_flags <= '0;
            r_valid <= 1'b0;
        end else if (w_clear_p) begin
            r_state <= StLoadA;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_flags <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                StLoadA: begin
                    if (w_enter_p) begin
                        r_a     <= bus.sw;
                        r_state <= StLoadB;
                    end
                end
                StLoadB: begin
                    if (w_enter_p) begin
                        r_b     <= bus.sw;
                        r_state <= StLoadOp;
                    end
                end
                StLoadOp: begin
                    if (w_enter_p) begin
                        r_op    <= bus.sw[1:0];
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    // Operands have been on the ALU for a full cycle; latch its flags.
                    r_flags <= bus.alu_flags;
                    r_valid <= 1'b1;
                    r_state <= StShow;
                end
                StShow: begin
                    if (w_enter_p) begin
                        r_valid <= 1'b0;
                        r_state <= StLoadA;
                    end
                end
                default: begin
                    r_state <= StLoadA;
                    r_a     <= '0;
                    r_b     <= '0;
                    r_op    <= '0;
                    r_flags <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a            = r_a;
    assign bus.b            = r_b;
    assign bus.alu_control  = r_op;
    assign bus.flags_hold   = r_flags;
    assign bus.result_valid = r_valid;
    assign bus.state        = r_state;

endmodule
